// File: rtl/io_uart_tx.sv
// rtl/io_uart_tx.sv - memory-mapped 8N1 UART transmitter with a transmit FIFO
module io_uart_tx #(
    parameter logic [31:0] BASE_ADDRESS    = 32'hffff0000,
    parameter int          FIFO_DEPTH      = 8,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd27
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_write_en,
    input  logic        io_read_en,
    input  logic [31:0] io_address,
    input  logic [31:0] io_write_data,
    output logic [31:0] io_read_data,
    output logic        uart_tx
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [7:0]     fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    fifo_count;
    logic [15:0]    divisor;
    logic [15:0]    bit_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift_reg;
    logic           overflow;
    logic           pop;
    logic           reload;
    logic [31:0]    rd_mux;
    logic           unused_write_bits;

    wire sel_status = (io_address == BASE_ADDRESS);
    wire sel_tx     = (io_address == BASE_ADDRESS + 32'd4);
    wire sel_div    = (io_address == BASE_ADDRESS + 32'd8);

    wire fifo_empty = (fifo_count == '0);
    wire not_full   = (fifo_count < DEPTH_CNT);
    wire tx_idle    = fifo_empty && (state == ST_IDLE);
    wire push_req   = io_write_en && sel_tx;
    wire push_ok    = push_req && not_full;
    wire push_drop  = push_req && !not_full;

    assign unused_write_bits = &{1'b0, io_write_data[31:16]};

    // Memory has no reset: a flush only needs the pointers and count cleared.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= io_write_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        reload     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    reload     = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (bit_cnt == 16'd0) begin
                    reload     = 1'b1;
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_cnt == 16'd0) begin
                    reload = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (bit_cnt == 16'd0) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        reload     = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The bit counter samples DIVISOR only on reload, so a new value waits for the next bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= 16'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'd0;
        end else begin
            state <= state_next;
            if (pop) begin
                shift_reg <= fifo_mem[rd_ptr];
            end
            if (reload) begin
                bit_cnt <= divisor - 16'd1;
            end else if (bit_cnt != 16'd0) begin
                bit_cnt <= bit_cnt - 16'd1;
            end
            if (pop) begin
                bit_idx <= 3'd0;
            end else if (state == ST_DATA && reload) begin
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    always_comb begin
        uart_tx = 1'b1;
        case (state)
            ST_START: uart_tx = 1'b0;
            ST_DATA:  uart_tx = shift_reg[bit_idx];
            default:  uart_tx = 1'b1;
        endcase
    end

    always_comb begin
        rd_mux = 32'd0;
        if (sel_status) begin
            rd_mux = {16'd0, 8'(fifo_count), 5'd0, overflow, tx_idle, not_full};
        end else if (sel_div) begin
            rd_mux = {16'd0, divisor};
        end
    end

    // A rejected push outranks a same-cycle W1C so the drop is never lost.
    always_ff @(posedge clk) begin
        if (!reset) begin
            divisor      <= DEFAULT_DIVISOR;
            overflow     <= 1'b0;
            io_read_data <= 32'd0;
        end else begin
            if (io_write_en && sel_div) begin
                divisor <= (io_write_data[15:0] == 16'd0) ? 16'd1 : io_write_data[15:0];
            end
            if (push_drop) begin
                overflow <= 1'b1;
            end else if (io_write_en && sel_status && io_write_data[2]) begin
                overflow <= 1'b0;
            end
            if (io_read_en) begin
                io_read_data <= rd_mux;
            end
        end
    end

endmodule

// File: doc/io_uart_tx.md
Name: io_uart_tx

Overview:
- Memory-mapped UART transmitter on the non-cacheable IO bus, i.e. the target end of the io_write_en/io_read_en/io_address/io_write_data/io_read_data interface driven by the core-side IO arbiter.
- Decodes a small register window, buffers transmit bytes in a FIFO and serializes them as 8N1 frames on a serial pin.
- Returns status and configuration on io_read_data.
- Sits at the SoC/FPGA top level beside the gpgpu instance.

Parameters:
- BASE_ADDRESS, 32'hffff0000, word-aligned base of the 3-register window.
- FIFO_DEPTH, 8, transmit FIFO entries; must be a power of two, at least 2.
- DEFAULT_DIVISOR, 16'd27, clocks per serial bit after reset.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset; asserted (0) for at least one clk edge.
- io_write_en  input  1  write strobe, one cycle per access.
- io_read_en  input  1  read strobe, one cycle per access.
- io_address  input  32  byte address of the access.
- io_write_data  input  32  write data.
- io_read_data  output  32  registered read data.
- uart_tx  output  1  serial output, idle high.

Behaviour:
- Register map (byte offsets from BASE_ADDRESS); other addresses are ignored.
  - +0 STATUS, R/W1C.
    - bit0 = fifo_not_full.
    - bit1 = tx_idle (FIFO empty and shifter in IDLE).
    - bit2 = overflow (sticky).
    - [15:8] = FIFO count.
    - Other bits read 0.
    - Writing 1 to bit2 clears overflow; writes to all other bits are ignored.
  - +4 TX_DATA, W.
    - A write pushes io_write_data[7:0] into the FIFO.
    - A read returns 0.
  - +8 DIVISOR, R/W, [15:0].
    - Reads return the stored value, zero-extended.
    - A written value of 0 is stored as 1.
- Read timing: io_read_data is registered and valid exactly one cycle after io_read_en.
  - An unmapped read loads 0.
  - When io_read_en is low, io_read_data holds its previous value.
- If io_read_en and io_write_en are asserted together, the write takes effect and the read returns the pre-write value.
- Push rules:
  - A push is accepted only if count < FIFO_DEPTH at the start of the cycle.
  - A same-cycle pop does not free a slot for that push.
  - A rejected push drops the byte and sets overflow.
  - If a W1C clear and a rejected push land in the same cycle, overflow ends set.
- FIFO: circular buffer with wrapping read/write pointers and a separate count of width log2(FIFO_DEPTH)+1. A simultaneous push and pop leaves count unchanged.
- TX state machine, one bit time = DIVISOR clocks, counted by the bit counter:
  - IDLE: uart_tx=1.
    - If FIFO is non-empty: pop the head into the shift register, load the bit counter, go to START.
    - A byte pushed into an empty FIFO leaves IDLE on the cycle after the push.
  - START: uart_tx=0 for one bit time, then go to DATA.
  - DATA: 8 bits, LSB first, each one bit time, tracked by a 3-bit index; after bit 7, go to STOP.
  - STOP: uart_tx=1 for one bit time.
    - If FIFO is non-empty, pop and go directly to START (back-to-back frames, no extra idle).
    - Otherwise go to IDLE.
- A DIVISOR write mid-frame takes effect at the next bit-counter reload; the current bit completes with the old value.
- Reset (reset==0 at a clk edge), including mid-frame:
  - FIFO flushed, count=0.
  - State=IDLE.
  - uart_tx=1.
  - io_read_data=0.
  - overflow=0.
  - DIVISOR=DEFAULT_DIVISOR.
  - All outputs hold these values from the first edge with reset low.

Test Plan:
- Reset, then read +8 -> io_read_data=32'd27 one cycle later. Read +0 -> 32'h00000003 (not full, idle, count 0).
- DIVISOR=4, write 8'hA5 to +4 -> uart_tx low 4 clk (start), then bits 1,0,1,0,0,1,0,1 at 4 clk each, then high 4 clk. Frame is 40 clk total; tx_idle returns to 1 after the stop bit.
- DIVISOR=2, push 10 bytes 8'h00..8'h09 back-to-back while the first frame is serializing.
  - Accepted: 8'h00..8'h08; the first pops on the cycle after its push.
  - 8'h09 is dropped and STATUS bit2=1.
  - Frames 8'h00..8'h08 are emitted with no gap between stop bit and next start bit.
  - Writing 32'h4 to +0 clears bit2.
- Write DIVISOR=0 -> reads back 1; an 8'hFF frame lasts 10 clk.
- Mid-frame (in DATA), drive reset low one cycle -> uart_tx=1 on that edge, STATUS=32'h00000003, DIVISOR=27, and no further frame is emitted.
- Read unmapped BASE_ADDRESS+12 -> io_read_data=0. A write there changes no state.
